// File: rtl/pif_reg_sequencer_pkg.sv
// pif_reg_sequencer_pkg: byte tags, payload width and sequencer states shared by the pif register sequencer.
package pif_reg_sequencer_pkg;
    localparam int I2C_DATA_BITS = 6;
    localparam logic [1:0] A_ADDR = 2'b10;
    localparam logic [1:0] D_ADDR = 2'b01;
    typedef enum logic [1:0] {
        PIF_SEQ_IDLE,
        PIF_SEQ_WR_REQ,
        PIF_SEQ_RD_REQ,
        PIF_SEQ_RD_DONE
    } pif_seq_state_t;
endpackage

// File: rtl/pif_reg_sequencer.sv
// pif_reg_sequencer: turns tagged I2C slave bytes into register-bus writes/reads through an auto-incrementing pointer.
module pif_reg_sequencer
    import pif_reg_sequencer_pkg::*;
#(
    parameter bit AUTO_INC  = 1'b1,
    parameter int TIMEOUT   = 255,
    parameter int REG_COUNT = 64
) (
    input  logic       i2c_clk,
    input  logic       rst,
    input  logic       rx_stb,
    input  logic [7:0] rx_data,
    input  logic       rx_stop,
    input  logic       tx_req,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic [5:0] reg_addr,
    output logic [5:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [5:0] reg_rdata,
    input  logic       reg_ack,
    output logic       busy,
    output logic       err
);
    localparam logic [6:0] ADDR_LIMIT = 7'(REG_COUNT);
    localparam logic [5:0] PTR_LAST   = 6'(REG_COUNT - 1);
    localparam logic [7:0] CNT_LAST   = 8'(TIMEOUT - 1);

    pif_seq_state_t state, state_n;
    logic [5:0] ptr, wdata, rdata, ptr_inc, payload;
    logic [1:0] tag;
    logic [7:0] cnt;
    logic       idle, in_req, expire, done, rd_timed_out, err_q, unused_stop;

    assign tag         = rx_data[7:6];
    assign payload     = rx_data[I2C_DATA_BITS-1:0];
    assign idle        = state == PIF_SEQ_IDLE;
    assign in_req      = state == PIF_SEQ_WR_REQ || state == PIF_SEQ_RD_REQ;
    assign expire      = in_req && !reg_ack && cnt == CNT_LAST;
    assign done        = in_req && (reg_ack || expire);
    assign ptr_inc     = !AUTO_INC ? ptr : ptr == PTR_LAST ? '0 : ptr + 6'd1;
    assign unused_stop = rx_stop;

    always_ff @(posedge i2c_clk or posedge rst) begin
        if (rst)
            state <= PIF_SEQ_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            PIF_SEQ_IDLE:   state_n = rx_stb ? (tag == D_ADDR ? PIF_SEQ_WR_REQ : PIF_SEQ_IDLE)
                                    : tx_req ? PIF_SEQ_RD_REQ : PIF_SEQ_IDLE;
            PIF_SEQ_WR_REQ: state_n = done ? PIF_SEQ_IDLE : PIF_SEQ_WR_REQ;
            PIF_SEQ_RD_REQ: state_n = done ? PIF_SEQ_RD_DONE : PIF_SEQ_RD_REQ;
            default:        state_n = PIF_SEQ_IDLE;
        endcase
    end

    always_ff @(posedge i2c_clk or posedge rst) begin
        if (rst) begin
            ptr          <= '0;
            wdata        <= '0;
            rdata        <= '0;
            cnt          <= '0;
            rd_timed_out <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            cnt <= in_req ? cnt + 8'd1 : '0;
            if (idle && rx_stb && tag == A_ADDR) begin
                if ({1'b0, payload} < ADDR_LIMIT)
                    ptr <= payload;
                err_q <= {1'b0, payload} >= ADDR_LIMIT;
            end else if (expire || (rx_stb && !(idle && tag == D_ADDR))) begin
                err_q <= 1'b1;
            end
            if (idle && rx_stb && tag == D_ADDR)
                wdata <= payload;
            // a timed-out read still answers the master, with all-ones data
            if (state == PIF_SEQ_RD_REQ && done) begin
                rdata        <= reg_ack ? reg_rdata : 6'h3F;
                rd_timed_out <= !reg_ack;
            end
            if ((state == PIF_SEQ_WR_REQ && reg_ack) || (state == PIF_SEQ_RD_DONE && !rd_timed_out))
                ptr <= ptr_inc;
        end
    end

    assign reg_we    = state == PIF_SEQ_WR_REQ;
    assign reg_re    = state == PIF_SEQ_RD_REQ;
    assign tx_valid  = state == PIF_SEQ_RD_DONE;
    assign tx_data   = tx_valid ? {D_ADDR, rdata} : '0;
    assign reg_addr  = ptr;
    assign reg_wdata = wdata;
    assign busy      = !idle;
    assign err       = err_q;
endmodule
